serial_add_sequencer: RTL

Bit-serial add/subtract controller built around the team's half-adder datapath. Two half-adder cells plus an OR form one full-adder slice. The sequencer shifts latched operands through that slice LSB-first, one bit per clock, and accumulates sum bits and the final carry. It sits in the user-project wrapper between the dedicated inputs and the output pins.

---
 rtl/serial_add_sequencer.sv | 90 +++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: operands shift LSB-first through a full-adder slice built from two half adders.
// Result after WIDTH+1 edges from accepted start; one op per WIDTH+2 cycles, start ignored outside IDLE.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_a, shift_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             p, g1, s, g2, carry_out;
  logic             accept, last_step;

  half_adder u_ha1 (.a(shift_a[0]), .b(shift_b[0]), .s(p), .c(g1));
  half_adder u_ha2 (.a(p), .b(carry), .s(s), .c(g2));
  assign carry_out = g1 | g2;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Subtract is A + ~B + 1: inverted B latched, carry-in seeded with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a <= '0;
      shift_b <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      shift_a <= op_a;
      shift_b <= sub ? ~op_b : op_b;
      carry   <= sub;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == RUN) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      carry   <= carry_out;
      cnt     <= cnt + 1'b1;
      sum     <= {s, sum[WIDTH-1:1]};
      if (last_step) cout <= carry_out;
    end
  end
endmodule
